// File: rtl/ppm16_mod.sv
// 16-PPM packet transmitter: preamble, 2-symbol length header, data symbols.
// Ports: clk, reset, tx_start, data_len, sym_in/sym_valid/sym_ready, dout, busy, done, underrun.
module ppm16_mod #(
  parameter int          CHIP_BITS     = 2,
  parameter int          PREAMBLE_SYMS = 4,
  parameter logic [3:0]  PREAMBLE_SYM  = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] data_len,
  input  logic [3:0] sym_in,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic       dout,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam int CW = (CHIP_BITS > 1) ? $clog2(CHIP_BITS) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CHIP_BITS - 1);
  localparam logic [7:0]    PRE_LAST = 8'(PREAMBLE_SYMS - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_HDR  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Registers describe the chip cycle currently on dout.
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cyc_q,   cyc_d;
  logic [3:0]    chip_q,  chip_d;
  logic [7:0]    sym_q,   sym_d;
  logic [3:0]    cur_q,   cur_d;
  logic          blank_q, blank_d;
  logic [7:0]    len_q,   len_d;
  logic          ur_q,    ur_d;
  logic          dout_q,  dout_d;

  logic sym_last;
  logic fetch;
  logic tx_d;

  assign sym_last = (chip_q == 4'd15) && (cyc_q == CYC_LAST);

  // Pull on the last cycle of a symbol followed by a data symbol.
  assign fetch = sym_last &&
    (((state_q == S_HDR) && (sym_q == 8'd1) && (len_q != 8'd0)) ||
     ((state_q == S_DATA) && (sym_q != len_q - 8'd1)));

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    chip_d  = chip_q;
    sym_d   = sym_q;
    cur_d   = cur_q;
    blank_d = blank_q;
    len_d   = len_q;
    ur_d    = ur_q;

    unique case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          state_d = S_PRE;
          cyc_d   = '0;
          chip_d  = 4'd0;
          sym_d   = 8'd0;
          cur_d   = PREAMBLE_SYM;
          blank_d = 1'b0;
          len_d   = data_len;
          ur_d    = 1'b0;
        end
      end
      S_PRE, S_HDR, S_DATA: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d  = '0;
          chip_d = chip_q + 4'd1;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
        if (sym_last) begin
          unique case (state_q)
            S_PRE: begin
              if (sym_q == PRE_LAST) begin
                state_d = S_HDR;
                sym_d   = 8'd0;
                cur_d   = len_q[7:4];
              end else begin
                sym_d = sym_q + 8'd1;
              end
            end
            S_HDR: begin
              if (sym_q == 8'd0) begin
                sym_d = 8'd1;
                cur_d = len_q[3:0];
              end else if (len_q == 8'd0) begin
                state_d = S_DONE;
              end else begin
                state_d = S_DATA;
                sym_d   = 8'd0;
              end
            end
            default: begin
              if (fetch) sym_d = sym_q + 8'd1;
              else       state_d = S_DONE;
            end
          endcase
        end
        if (fetch) begin
          cur_d   = sym_in;
          blank_d = !sym_valid;
          if (!sym_valid) ur_d = 1'b1;
        end
        if (state_d == S_DONE) begin
          cyc_d   = '0;
          chip_d  = 4'd0;
          sym_d   = 8'd0;
          blank_d = 1'b0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_d = (state_d == S_PRE) || (state_d == S_HDR) ||
                (state_d == S_DATA);
  assign dout_d = tx_d && !blank_d && (chip_d == cur_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      chip_q  <= 4'd0;
      sym_q   <= 8'd0;
      cur_q   <= 4'd0;
      blank_q <= 1'b0;
      len_q   <= 8'd0;
      ur_q    <= 1'b0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      chip_q  <= chip_d;
      sym_q   <= sym_d;
      cur_q   <= cur_d;
      blank_q <= blank_d;
      len_q   <= len_d;
      ur_q    <= ur_d;
      dout_q  <= dout_d;
    end
  end

  assign sym_ready = fetch;
  assign dout      = dout_q;
  assign busy      = (state_q == S_PRE) || (state_q == S_HDR) ||
                     (state_q == S_DATA);
  assign done      = (state_q == S_DONE);
  assign underrun  = ur_q;

endmodule
